logic_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered bitwise logic unit (OR/AND/XOR/NOR) among four requesters. Each requester presents two operands and an opcode. The block grants one requester at a time, captures its operands, computes the result, and holds it with a valid/ready handshake until it is accepted. It sits between the Level-1 gate datapaths and any client logic that needs gate results without owning a gate instance.

---
 rtl/logic_unit_arbiter.sv | 144 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: four requesters share one registered bitwise logic unit.
// A round-robin pick in IDLE captures the winner's operands, EXEC computes the
// result, and DONE holds it on a valid/ready handshake until it is accepted.
module logic_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   a_in,
    input  logic [4*WIDTH-1:0]   b_in,
    input  logic [7:0]           op_in,
    output logic [3:0]           gnt,
    output logic [WIDTH-1:0]     res_data,
    output logic [1:0]           res_id,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       id_q, id_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       own_q, own_d;

    logic [1:0]       win;

    // Bitwise unit; NOR is inverted in-width so no bits above WIDTH exist.
    function automatic logic [WIDTH-1:0] lu(input logic [1:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        case (op)
            OP_OR:   lu = a | b;
            OP_AND:  lu = a & b;
            OP_XOR:  lu = a ^ b;
            default: lu = ~(a | b);
        endcase
    endfunction

    // Round-robin pick: scan from ptr+3 down to ptr so the lowest offset wins.
    always_comb begin
        win = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
        end
    end

    // Next-state and datapath control for the IDLE/EXEC/DONE sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        id_d    = id_q;
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        own_d   = own_q;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (|req) begin
                    a_d     = a_in[int'(win)*WIDTH +: WIDTH];
                    b_d     = b_in[int'(win)*WIDTH +: WIDTH];
                    op_d    = op_in[int'(win)*2 +: 2];
                    own_d   = win;
                    gnt_d   = 4'b0001 << win;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = lu(op_q, a_q, b_q);
                id_d    = own_q;
                valid_d = 1'b1;
                gnt_d   = 4'b0000;
                state_d = DONE;
            end
            DONE: begin
                // Priority moves past the requester just served.
                if (valid_q && res_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = own_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            data_q  <= '0;
            id_q    <= 2'd0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'd0;
            own_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            own_q   <= own_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_data  = data_q;
    assign res_id    = id_q;
    assign res_valid = valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: opcode vector table, directed multi-cycle
// sequences, and randomized traffic against a transaction-level model.
module tb_logic_unit_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] a_in, b_in;
    logic [7:0]     op_in;
    logic [3:0]     gnt;
    logic [W-1:0]   res_data;
    logic [1:0]     res_id;
    logic           res_valid, res_ready, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .op_in(op_in), .gnt(gnt), .res_data(res_data), .res_id(res_id),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Step until a grant shows up; a missing grant is itself a failure.
    task automatic wait_gnt(input string name, output logic [3:0] g, output int cycles);
        g = 4'b0000;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cycles++;
            if (gnt != 4'b0000) begin
                g = gnt;
                return;
            end
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Reference logic op from a per-bit count of ones in the two operands.
    function automatic logic [W-1:0] ref_op(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            int s;
            s = int'(a[i]) + int'(b[i]);
            case (op)
                2'd0:    r[i] = (s >= 1);
                2'd1:    r[i] = (s == 2);
                2'd2:    r[i] = (s == 1);
                default: r[i] = (s == 0);
            endcase
        end
        return r;
    endfunction

    initial begin
        vec_t       vt[8];
        int         exp4[5];
        int         exp2[4];
        logic [3:0] g;
        int         cyc;
        // transaction model state
        bit         m_have;
        int         m_age, m_ptr, m_id;
        logic [W-1:0] m_res;

        vt[0] = '{2, 2'd0, 8'hF0, 8'h3C, 8'hFC};
        vt[1] = '{2, 2'd1, 8'hF0, 8'h3C, 8'h30};
        vt[2] = '{2, 2'd2, 8'hF0, 8'h3C, 8'hCC};
        vt[3] = '{2, 2'd3, 8'hF0, 8'h3C, 8'h03};
        vt[4] = '{0, 2'd3, 8'h00, 8'h00, 8'hFF};
        vt[5] = '{3, 2'd2, 8'hFF, 8'hFF, 8'h00};
        vt[6] = '{1, 2'd1, 8'hAA, 8'hFF, 8'hAA};
        vt[7] = '{0, 2'd0, 8'h00, 8'h01, 8'h01};

        rst = 1'b1; req = 4'b0; a_in = '0; b_in = '0; op_in = '0; res_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_valid", 32'(res_valid), 0);
        chk("reset_data", 32'(res_data), 0);
        chk("reset_id", 32'(res_id), 0);
        chk("reset_busy", 32'(busy), 0);

        // Opcode table: single requester, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            a_in = $urandom; b_in = $urandom; op_in = $urandom;
            a_in[vt[i].id*W +: W] = vt[i].a;
            b_in[vt[i].id*W +: W] = vt[i].b;
            op_in[vt[i].id*2 +: 2] = vt[i].op;
            req = 4'(1 << vt[i].id);
            res_ready = 1'b1;
            tick();
            chk("vec_gnt", 32'(gnt), 32'(1 << vt[i].id));
            chk("vec_busy", 32'(busy), 1);
            req = 4'b0;
            tick();
            chk("vec_gnt_pulse", 32'(gnt), 0);
            chk("vec_valid", 32'(res_valid), 1);
            chk("vec_data", 32'(res_data), 32'(vt[i].exp));
            chk("vec_id", 32'(res_id), 32'(vt[i].id));
            tick();
            chk("vec_accept_valid", 32'(res_valid), 0);
            chk("vec_accept_busy", 32'(busy), 0);
        end

        // Fairness with every requester active.
        exp4 = '{0, 1, 2, 3, 0};
        do_reset(2);
        req = 4'b1111; res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("rr4", g, cyc);
            chk("rr4_gnt", 32'(g), 32'(1 << exp4[k]));
            if (k > 0) chk("rr4_gap", 32'(cyc), 3);
        end

        // Fairness with two sparse requesters.
        exp2 = '{1, 3, 1, 3};
        req = 4'b0;
        do_reset(2);
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_gnt("rr2", g, cyc);
            chk("rr2_gnt", 32'(g), 32'(1 << exp2[k]));
        end
        req = 4'b0;
        repeat (3) tick();

        // Backpressure: result must hold for five stalled cycles.
        do_reset(2);
        res_ready = 1'b0;
        a_in[0 +: W] = 8'h5A; b_in[0 +: W] = 8'h0F; op_in[1:0] = 2'd2;
        req = 4'b0001;
        wait_gnt("bp", g, cyc);
        req = 4'b0;
        tick();
        chk("bp_valid", 32'(res_valid), 1);
        chk("bp_data", 32'(res_data), 32'h55);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_data", 32'(res_data), 32'h55);
            chk("bp_hold_id", 32'(res_id), 0);
            chk("bp_hold_valid", 32'(res_valid), 1);
            chk("bp_hold_busy", 32'(busy), 1);
            chk("bp_hold_gnt", 32'(gnt), 0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(res_valid), 0);
        chk("bp_release_busy", 32'(busy), 0);

        // Operand capture: winner's inputs change after the grant.
        a_in[W +: W] = 8'hC3; b_in[W +: W] = 8'h00; op_in[3:2] = 2'd0;
        req = 4'b0010;
        wait_gnt("cap", g, cyc);
        chk("cap_gnt", 32'(g), 32'b0010);
        req = 4'b0;
        a_in[W +: W] = 8'h00; op_in[3:2] = 2'd1;
        tick();
        chk("cap_data", 32'(res_data), 32'hC3);
        tick();

        // Late request arriving in DONE must wait for IDLE.
        do_reset(2);
        res_ready = 1'b0;
        req = 4'b0001;
        wait_gnt("late", g, cyc);
        chk("late_first", 32'(g), 32'b0001);
        req = 4'b0;
        tick();
        req = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("late_no_gnt", 32'(gnt), 0);
        end
        res_ready = 1'b1;
        tick();
        chk("late_accept_gnt", 32'(gnt), 0);
        chk("late_accept_busy", 32'(busy), 0);
        tick();
        chk("late_gnt", 32'(gnt), 32'b1000);
        req = 4'b0;
        repeat (2) tick();

        // Reset in DONE discards the pending result.
        res_ready = 1'b0;
        a_in[2*W +: W] = 8'hFF; op_in[5:4] = 2'd0;
        req = 4'b0100;
        wait_gnt("rd", g, cyc);
        req = 4'b0;
        tick();
        chk("rd_valid_before", 32'(res_valid), 1);
        req = 4'b1111;
        do_reset(2);
        chk("rd_gnt", 32'(gnt), 0);
        chk("rd_valid", 32'(res_valid), 0);
        chk("rd_data", 32'(res_data), 0);
        chk("rd_busy", 32'(busy), 0);
        res_ready = 1'b1;
        wait_gnt("rd_next", g, cyc);
        chk("rd_next_gnt", 32'(g), 32'b0001);
        req = 4'b0;
        repeat (2) tick();

        // Randomized traffic against the transaction model.
        m_have = 0; m_age = 0; m_ptr = 0; m_id = 0; m_res = '0;
        for (int i = 0; i < 600; i++) begin
            rst = (i == 0) || ($urandom_range(0, 49) == 0);
            req = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            a_in = $urandom; b_in = $urandom; op_in = 8'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            if (rst) begin
                m_have = 0; m_ptr = 0;
            end else if (!m_have) begin
                if (req != 4'b0) begin
                    for (int k = 3; k >= 0; k--)
                        if (req[(m_ptr + k) % 4]) m_id = (m_ptr + k) % 4;
                    m_res = ref_op(op_in[m_id*2 +: 2], a_in[m_id*W +: W], b_in[m_id*W +: W]);
                    m_have = 1; m_age = 0;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (res_ready) begin
                m_have = 0;
                m_ptr = (m_id + 1) % 4;
            end
            tick();
            chk("rnd_gnt", 32'(gnt), (m_have && m_age == 0) ? 32'(1 << m_id) : 32'd0);
            chk("rnd_valid", 32'(res_valid), 32'(m_have && m_age == 1));
            chk("rnd_busy", 32'(busy), 32'(m_have));
            if (m_have && m_age == 1) begin
                chk("rnd_data", 32'(res_data), 32'(m_res));
                chk("rnd_id", 32'(res_id), 32'(m_id));
            end
        end

        rst = 1'b0; req = 4'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
